// File: rtl/scan_chain_pkg.sv
// Shared types and defaults for the scan chain controller.
package scan_chain_pkg;

    localparam int unsigned DEFAULT_CHAIN_LEN = 16;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } state_e;

endpackage

// File: rtl/scan_bit_counter.sv
// Bit counter for scan shifting: synchronous clear, enable, wrap at terminal count.
module scan_bit_counter #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned TERM  = 15
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_nxt_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] TermCnt = CNT_W'(TERM);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == TermCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Drives one scan test: shift pattern in, capture, shift response out, compare under mask.
module scan_chain_ctrl
    import scan_chain_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN)
) (
    input  logic                 CLK,
    input  logic                 R,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic [CHAIN_LEN-1:0] expect_in,
    input  logic [CHAIN_LEN-1:0] mask_in,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] result,
    output logic                 pass
);

    localparam logic [CNT_W-1:0] TermCnt = CNT_W'(CHAIN_LEN - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tc, accept, cnt_en;
    logic [CHAIN_LEN-1:0]   pattern_q, pattern_d, expect_q, expect_d, mask_q, mask_d;
    logic [CHAIN_LEN-1:0]   result_q, result_d;
    logic                   pass_q, pass_d;
    logic                   se_q, se_d, si_q, si_d, busy_q, busy_d, done_q, done_d;

    assign accept = (state_q == IDLE) && start;
    assign cnt_en = (state_q == SHIFT_IN) || (state_q == SHIFT_OUT);

    scan_bit_counter #(
        .CNT_W (CNT_W),
        .TERM  (CHAIN_LEN - 1)
    ) u_cnt (
        .CLK       (CLK),
        .R         (R),
        .clr_i     (accept),
        .en_i      (cnt_en),
        .cnt_o     (cnt_q),
        .cnt_nxt_o (cnt_d),
        .tc_o      (tc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (start) state_d = SHIFT_IN;
            SHIFT_IN:  if (tc) state_d = CAPTURE;
            CAPTURE:   state_d = SHIFT_OUT;
            SHIFT_OUT: if (tc) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so pins never glitch.
    always_comb begin
        pattern_d = pattern_q;
        expect_d  = expect_q;
        mask_d    = mask_q;
        result_d  = result_q;
        pass_d    = pass_q;
        if (accept) begin
            pattern_d = pattern_in;
            expect_d  = expect_in;
            mask_d    = mask_in;
            pass_d    = 1'b0;
        end
        if (state_q == SHIFT_OUT) begin
            result_d[TermCnt - cnt_q] = SO;
            if (tc) begin
                pass_d = (((result_d ^ expect_q) & mask_q) == '0);
            end
        end
        se_d   = (state_d == SHIFT_IN) || (state_d == SHIFT_OUT);
        si_d   = (state_d == SHIFT_IN) ? pattern_d[TermCnt - cnt_d] : 1'b0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            expect_q  <= '0;
            mask_q    <= '0;
            result_q  <= '0;
            pass_q    <= 1'b0;
            se_q      <= 1'b0;
            si_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            expect_q  <= expect_d;
            mask_q    <= mask_d;
            result_q  <= result_d;
            pass_q    <= pass_d;
            se_q      <= se_d;
            si_q      <= si_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign SE     = se_q;
    assign SI     = si_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign pass   = pass_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with a 4-flop behavioural scan chain.
module tb_scan_chain_ctrl;

    localparam int unsigned L = 4;

    logic         CLK = 1'b0;
    logic         R = 1'b1;
    logic         start = 1'b0;
    logic [L-1:0] pattern_in = '0;
    logic [L-1:0] expect_in = '0;
    logic [L-1:0] mask_in = '0;
    logic         SO;
    logic         SE, SI, busy, done, pass;
    logic [L-1:0] result;

    logic [L-1:0] chain = '0;
    logic [L-1:0] func = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    always_ff @(posedge CLK) begin
        if (SE) chain <= {chain[L-2:0], SI};
        else    chain <= func;
    end
    assign SO = chain[L-1];

    scan_chain_ctrl #(.CHAIN_LEN(L)) dut (
        .CLK        (CLK),
        .R          (R),
        .start      (start),
        .pattern_in (pattern_in),
        .expect_in  (expect_in),
        .mask_in    (mask_in),
        .SO         (SO),
        .SE         (SE),
        .SI         (SI),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .pass       (pass)
    );

    task automatic test_reset();
        R = 1'b1;
        #3;
        n_cmp++; if (SE !== 1'b0) begin n_bad++; $display("FAIL reset_se got %b want 0", SE); end
        n_cmp++; if (SI !== 1'b0) begin n_bad++; $display("FAIL reset_si got %b want 0", SI); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (result !== 4'b0000) begin n_bad++; $display("FAIL reset_result got %b want 0000", result); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass got %b want 0", pass); end
        @(negedge CLK);
        R = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    // One full sequence; e counts cycles after the accepting edge.
    task automatic test_sequence(input logic [L-1:0] pat, input logic [L-1:0] fnc,
                                 input logic [L-1:0] exp, input logic [L-1:0] msk,
                                 input logic exp_pass, input string tag);
        @(negedge CLK);
        pattern_in = pat; expect_in = exp; mask_in = msk; func = fnc; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            if (e > 0) begin @(posedge CLK); #1; end
            if (e <= 3) begin
                n_cmp++;
                if (SE !== 1'b1 || SI !== pat[3-e]) begin
                    n_bad++; $display("FAIL %s shift_in e=%0d SE=%b SI=%b want 1 %b", tag, e, SE, SI, pat[3-e]);
                end
            end
            if (e == 4) begin
                n_cmp++;
                if (chain !== pat || SE !== 1'b0) begin
                    n_bad++; $display("FAIL %s capture chain=%b SE=%b want %b 0", tag, chain, SE, pat);
                end
            end
            if (e >= 5 && e <= 8) begin
                n_cmp++;
                if (SE !== 1'b1 || SI !== 1'b0) begin
                    n_bad++; $display("FAIL %s shift_out e=%0d SE=%b SI=%b want 1 0", tag, e, SE, SI);
                end
            end
            n_cmp++;
            if (done !== (e == 9)) begin
                n_bad++; $display("FAIL %s done e=%0d got %b want %b", tag, e, done, e == 9);
            end
            n_cmp++;
            if (busy !== (e <= 9)) begin
                n_bad++; $display("FAIL %s busy e=%0d got %b want %b", tag, e, busy, e <= 9);
            end
            if (e == 9) begin
                n_cmp++;
                if (result !== fnc) begin n_bad++; $display("FAIL %s result got %b want %b", tag, result, fnc); end
                n_cmp++;
                if (pass !== exp_pass) begin n_bad++; $display("FAIL %s pass got %b want %b", tag, pass, exp_pass); end
            end
        end
    endtask

    task automatic test_pass_variants();
        test_sequence(4'b1011, 4'b0110, 4'b0110, 4'b1111, 1'b1, "exact_match");
        test_sequence(4'b1011, 4'b0110, 4'b0111, 4'b1111, 1'b0, "bit0_mismatch");
        test_sequence(4'b1011, 4'b0110, 4'b0111, 4'b1110, 1'b1, "bit0_masked");
        test_sequence(4'b0100, 4'b1001, 4'b1001, 4'b0000, 1'b1, "other_pattern");
    endtask

    task automatic test_start_ignored();
        int ndone;
        ndone = 0;
        @(negedge CLK);
        pattern_in = 4'b1011; expect_in = 4'b0110; mask_in = 4'b1111; func = 4'b0110; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int e = 0; e <= 14; e++) begin
            if (e > 0) begin @(posedge CLK); #1; end
            if (e == 6) begin pattern_in = 4'b0000; expect_in = 4'b1111; start = 1'b1; end
            if (e == 7) start = 1'b0;
            if (done === 1'b1) ndone++;
        end
        n_cmp++; if (ndone != 1) begin n_bad++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        n_cmp++; if (result !== 4'b0110) begin n_bad++; $display("FAIL ignore_result got %b want 0110", result); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL ignore_pass got %b want 1", pass); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        ndone = 0;
        @(negedge CLK);
        pattern_in = 4'b1011; expect_in = 4'b0110; mask_in = 4'b1111; func = 4'b0110; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        R = 1'b1;
        #1;
        n_cmp++; if (SE !== 1'b0) begin n_bad++; $display("FAIL midrst_se got %b want 0", SE); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_cmp++; if (result !== 4'b0000) begin n_bad++; $display("FAIL midrst_result got %b want 0000", result); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL midrst_pass got %b want 0", pass); end
        #1;
        R = 1'b0;
        for (int e = 0; e < 14; e++) begin
            @(posedge CLK); #1;
            if (done === 1'b1) ndone++;
            n_cmp++;
            if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_wait e=%0d busy got %b want 0", e, busy); end
        end
        n_cmp++; if (ndone != 0) begin n_bad++; $display("FAIL midrst_done_count got %0d want 0", ndone); end
        test_sequence(4'b1100, 4'b1001, 4'b1001, 4'b1111, 1'b1, "after_reset");
    endtask

    task automatic test_back_to_back();
        int ndone;
        int p;
        logic exp_se;
        ndone = 0;
        @(negedge CLK);
        pattern_in = 4'b0101; expect_in = 4'b1010; mask_in = 4'b1111; func = 4'b1010; start = 1'b1;
        @(posedge CLK); #1;
        for (int e = 0; e <= 33; e++) begin
            if (e > 0) begin @(posedge CLK); #1; end
            p = e % 11;
            if (e <= 32) begin
                exp_se = (p <= 3) || (p >= 5 && p <= 8);
                n_cmp++;
                if (SE !== exp_se) begin n_bad++; $display("FAIL b2b_se e=%0d got %b want %b", e, SE, exp_se); end
                n_cmp++;
                if (done !== (p == 9)) begin n_bad++; $display("FAIL b2b_done e=%0d got %b want %b", e, done, p == 9); end
            end
            if (done === 1'b1) ndone++;
            if (e == 31) start = 1'b0;
        end
        n_cmp++; if (ndone != 3) begin n_bad++; $display("FAIL b2b_done_count got %0d want 3", ndone); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_final_busy got %b want 0", busy); end
        n_cmp++; if (result !== 4'b1010) begin n_bad++; $display("FAIL b2b_result got %b want 1010", result); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL b2b_pass got %b want 1", pass); end
    endtask

    initial begin
        test_reset();
        test_pass_variants();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 16, number of scan flops in the driven chain (legal 2..256).
REQ-002 SHALL have parameter CNT_W, default $clog2(CHAIN_LEN), width of the internal bit counter.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 R  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request one test sequence; sampled only in IDLE.
REQ-006 pattern_in  input  CHAIN_LEN  stimulus; bit k is loaded into chain flop k (flop 0 nearest SI).
REQ-007 expect_in  input  CHAIN_LEN  expected captured response.
REQ-008 mask_in  input  CHAIN_LEN  1 = compare bit, 0 = don't care.
REQ-009 SO  input  1  scan-out, the Q of chain flop CHAIN_LEN-1.
REQ-010 SE  output  1  scan enable, drives the chain select pins (1 = scan data path, 0 = functional path).
REQ-011 SI  output  1  scan-in, drives the scan-data input of chain flop 0.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at sequence end.
REQ-014 result  output  CHAIN_LEN  captured response; bit k = value captured by flop k.
REQ-015 pass  output  1  ((result ^ expect) & mask) == 0; valid from the done pulse until the next accepted start.

Function
REQ-016 SHALL implement the FSM IDLE -> SHIFT_IN -> CAPTURE -> SHIFT_OUT -> DONE -> IDLE.
REQ-017 IDLE: start=1 at a rising edge latches pattern_in, expect_in and mask_in, clears the counter and enters SHIFT_IN; start=0 stays in IDLE.
REQ-018 start SHALL be ignored in all states other than IDLE; latched vectors SHALL NOT change until the next accepted start.
REQ-019 SHIFT_IN: lasts exactly CHAIN_LEN cycles; in counter cycle i: SE=1, SI=pattern[CHAIN_LEN-1-i]; the counter wraps to 0 on exit.
REQ-020 CAPTURE: exactly 1 cycle with SE=0 and SI=0, so the chain loads its functional data.
REQ-021 SHIFT_OUT: lasts exactly CHAIN_LEN cycles; in counter cycle j: SE=1, SI=0; SO is sampled at the closing edge into result[CHAIN_LEN-1-j].
REQ-022 DONE: 1 cycle with done=1, SE=0 and pass valid; then return to IDLE.
REQ-023 With start accepted at edge 0, done SHALL be high in the cycle after edge 2*CHAIN_LEN+1; busy SHALL cover that whole interval.
REQ-024 SE, SI, busy and done SHALL be pure Moore decodes of the state and counter, glitch-free relative to CLK.
REQ-025 start held high continuously SHALL produce back-to-back sequences with exactly one IDLE cycle between them.
REQ-026 Counter arithmetic SHALL be CNT_W bits unsigned; the terminal count is CHAIN_LEN-1; there is no overflow path.

Reset
REQ-027 R=1 SHALL asynchronously force the state to IDLE and clear the counter.
REQ-028 R=1 SHALL asynchronously clear SE, SI, busy, done, result, pass and the latched vectors to 0.
REQ-029 R asserted mid-sequence SHALL abort the sequence with no done pulse; after R deasserts, the block SHALL wait in IDLE for a new start.

Structure
REQ-030 Package scan_chain_pkg SHALL hold the state enum (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE) and the default CHAIN_LEN constant.
REQ-031 Sub-module scan_bit_counter (CNT_W-bit counter with clear, enable and terminal-count flag, async active-high R) SHALL be instantiated once; all other logic lives in scan_chain_ctrl.

Verification (CHAIN_LEN=4, 4 behavioural scan flops chained; functional input of flop k driven by a TB vector)
REQ-032 Pattern 4'b1011 shifted in, functional data 4'b0110 -> chain holds 1011 at CAPTURE entry; result=0110, done pulse in the cycle after edge 9.
REQ-033 expect=0110, mask=1111 -> pass=1; expect=0111, mask=1111 -> pass=0; expect=0111, mask=1110 -> pass=1.
REQ-034 start pulsed during SHIFT_OUT with a new pattern_in -> ignored; result and pass unchanged; exactly one done pulse.
REQ-035 R pulsed during SHIFT_IN cycle 2 -> SE=0, busy=0 and result=0 immediately; no done pulse; the next start completes normally.
REQ-036 start held high for 3 sequences -> 3 done pulses spaced 11 cycles apart; SE low exactly during CAPTURE, DONE and IDLE cycles.
